// File: rtl/sobel_defs_pkg.sv
// Shared definitions for the Sobel stage: direction codes, tangent thresholds,
// FSM states, window column type and small arithmetic helpers.
package sobel_defs;

  typedef enum logic [1:0] {
    DIR_H    = 2'd0,
    DIR_D45  = 2'd1,
    DIR_V    = 2'd2,
    DIR_D135 = 2'd3
  } dir_e;

  // tan(22.5) and tan(67.5) in Q8
  localparam int unsigned TAN22 = 106;
  localparam int unsigned TAN67 = 618;

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_ACTIVE    = 2'd1,
    S_PAD_RIGHT = 2'd2,
    S_FLUSH     = 2'd3
  } state_e;

  // One window column: top, middle and bottom pixels.
  typedef struct packed {
    logic [7:0] t;
    logic [7:0] m;
    logic [7:0] b;
  } col_t;

  function automatic logic [9:0] abs11(input logic signed [10:0] v);
    return v[10] ? 10'(-v) : v[9:0];
  endfunction

  function automatic dir_e quant_dir(input logic signed [10:0] gx,
                                     input logic signed [10:0] gy);
    logic [9:0]  ax;
    logic [9:0]  ay;
    logic [19:0] ay_s;
    logic [19:0] ax_lo;
    logic [19:0] ax_hi;
    logic        same;
    ax    = abs11(gx);
    ay    = abs11(gy);
    ay_s  = {2'b00, ay, 8'd0};
    ax_lo = 20'(ax) * 20'(TAN22);
    ax_hi = 20'(ax) * 20'(TAN67);
    same  = (gx[10] == gy[10]) || (gx == '0) || (gy == '0);
    if ((gx == '0 && gy == '0) || ay_s < ax_lo) return DIR_H;
    if (ay_s > ax_hi)                           return DIR_V;
    return same ? DIR_D45 : DIR_D135;
  endfunction

endpackage

// File: rtl/sobel_stage_line_buffer_2.sv
// Two row RAMs acting as a row shift register: one read/write per column, giving
// rows y-1 and y at the column currently arriving for row y+1.
module line_buffer_2 #(
  parameter  int unsigned IMG_WIDTH = 1920,
  localparam int unsigned AW        = $clog2(IMG_WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    row_prev,
  output logic [7:0]    row_cur
);

  logic [7:0] ram_prev [IMG_WIDTH];
  logic [7:0] ram_cur  [IMG_WIDTH];

  // Read-before-write: outputs show the rows stored before this column's update.
  assign row_prev = ram_prev[addr];
  assign row_cur  = ram_cur[addr];

  // NOTE: the RAMs have no reset; their contents are never used before being
  // written, and resetting them would prevent mapping onto block RAM.
  // NOTE: sequential state uses non-blocking assignments so that ram_prev
  // captures the old ram_cur value, not the one written this cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      ram_cur[addr]  <= wdata;
      ram_prev[addr] <= ram_cur[addr];
    end
  end

endmodule

// File: rtl/sobel_stage.sv
// 3x3 Sobel gradient stage: replicate-padded window over a two-row line buffer,
// two-stage compute pipeline and AXI-Stream in/out with whole-pipeline stall.
module sobel_stage
  import sobel_defs::*;
#(
  parameter int unsigned IMG_WIDTH  = 1920,
  parameter int unsigned IMG_HEIGHT = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_err
);

  localparam int unsigned XW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned AW = $clog2(IMG_WIDTH);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_END      = XW'(IMG_WIDTH);
  localparam logic [XW-1:0] X_ONE      = XW'(1);
  localparam logic [YW-1:0] Y_PRE_LAST = YW'(IMG_HEIGHT - 2);

  state_e             state, state_nx;
  logic [XW-1:0]      x_cnt, x_nx;
  logic [YW-1:0]      y_cnt, y_nx;
  logic               adv, accept, lb_we, col_en, produce, pad_cyc, first_px;
  logic [7:0]         lb_prev, lb_cur;
  col_t               new_col, col_a, col_b, win_l, win_c, win_r;
  logic               w_valid, w_last, w_user;
  logic               s1_valid, s1_last, s1_user;
  logic signed [10:0] gx_c, gy_c, s1_gx, s1_gy;
  logic [10:0]        sum_l, sum_r, sum_t, sum_b, mag;

  line_buffer_2 #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
    .clk      (clk),
    .we       (lb_we),
    .addr     (x_cnt[AW-1:0]),
    .wdata    (s_tdata),
    .row_prev (lb_prev),
    .row_cur  (lb_cur)
  );

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    adv      = !m_tvalid || m_tready;
    s_tready = !rst && adv && (state == S_FILL || state == S_ACTIVE);
    accept   = s_tvalid && s_tready;
    state_nx = state;
    x_nx     = x_cnt;
    y_nx     = y_cnt;
    lb_we    = 1'b0;
    col_en   = 1'b0;
    produce  = 1'b0;
    pad_cyc  = 1'b0;
    case (state)
      S_FILL: if (accept) begin
        lb_we = 1'b1;
        if (x_cnt == X_LAST) begin
          x_nx     = '0;
          state_nx = S_ACTIVE;
        end else begin
          x_nx = x_cnt + X_ONE;
        end
      end
      S_ACTIVE: if (accept) begin
        lb_we   = 1'b1;
        col_en  = 1'b1;
        produce = (x_cnt != '0);
        if (x_cnt == X_LAST) begin
          x_nx     = '0;
          state_nx = S_PAD_RIGHT;
        end else begin
          x_nx = x_cnt + X_ONE;
        end
      end
      S_PAD_RIGHT: if (adv) begin
        produce  = 1'b1;
        pad_cyc  = 1'b1;
        y_nx     = y_cnt + YW'(1);
        state_nx = (y_cnt < Y_PRE_LAST) ? S_ACTIVE : S_FLUSH;
      end
      S_FLUSH: if (adv) begin
        produce = (x_cnt != '0);
        if (x_cnt == X_END) begin
          pad_cyc  = 1'b1;
          x_nx     = '0;
          y_nx     = '0;
          state_nx = S_FILL;
        end else begin
          col_en = 1'b1;
          x_nx   = x_cnt + X_ONE;
        end
      end
      default: state_nx = S_FILL;
    endcase
  end

  assign first_px = (state == S_ACTIVE) && (y_cnt == '0) && (x_cnt == X_ONE);

  // Top row replicates on y=0; during flush the bottom row replicates row H-1.
  assign new_col.t = (y_cnt == '0) ? lb_cur : lb_prev;
  assign new_col.m = lb_cur;
  assign new_col.b = (state == S_FLUSH) ? lb_cur : s_tdata;

  assign sum_l = {3'b0, win_l.t} + {2'b0, win_l.m, 1'b0} + {3'b0, win_l.b};
  assign sum_r = {3'b0, win_r.t} + {2'b0, win_r.m, 1'b0} + {3'b0, win_r.b};
  assign sum_t = {3'b0, win_l.t} + {2'b0, win_c.t, 1'b0} + {3'b0, win_r.t};
  assign sum_b = {3'b0, win_l.b} + {2'b0, win_c.b, 1'b0} + {3'b0, win_r.b};
  assign gx_c  = $signed(sum_r - sum_l);
  assign gy_c  = $signed(sum_b - sum_t);
  assign mag   = {1'b0, abs11(s1_gx)} + {1'b0, abs11(s1_gy)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      x_cnt     <= '0;
      y_cnt     <= '0;
      frame_err <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      w_user    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_user   <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
    end else begin
      if (accept && ((s_tuser && !(state == S_FILL && x_cnt == '0)) ||
                     (s_tlast != (x_cnt == X_LAST))))
        frame_err <= 1'b1;
      if (adv) begin
        state    <= state_nx;
        x_cnt    <= x_nx;
        y_cnt    <= y_nx;
        w_valid  <= produce;
        w_last   <= pad_cyc;
        w_user   <= first_px;
        s1_valid <= w_valid;
        s1_last  <= w_last;
        s1_user  <= w_user;
        m_tvalid <= s1_valid;
        if (s1_valid) begin
          m_tdata <= {3'b000, quant_dir(s1_gx, s1_gy), mag};
          m_tlast <= s1_last;
          m_tuser <= s1_user;
        end
      end
    end
  end

  // Datapath registers carry no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (produce) begin
        win_l <= (!pad_cyc && x_cnt == X_ONE) ? col_a : col_b;
        win_c <= col_a;
        win_r <= pad_cyc ? col_a : new_col;
      end
      if (col_en) begin
        col_b <= col_a;
        col_a <= new_col;
      end
      s1_gx <= gx_c;
      s1_gy <= gy_c;
    end
  end

endmodule

// File: tb/tb_sobel_stage.sv
// Self-checking bench for sobel_stage: reference convolution model feeding a
// scoreboard queue, a table of hand-derived spot values, and reset/framing cases.
module tb_sobel_stage;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser, frame_err;

  always #5 clk = ~clk;

  sobel_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    int pat;
    int x;
    int y;
    int mag;
    int dir;
  } spot_t;

  beat_t       exp_q[$];
  spot_t       spots[$];
  int          img [H][W];
  logic [15:0] cap [N];
  logic [15:0] ref_cap [N];
  int          checks = 0;
  int          errors = 0;
  int          pos = 0;
  int          frame_outs = 0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic abort(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles without progress", name, waited);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  endtask

  function automatic int px(input int x, input int y);
    int cx, cy;
    cx = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
    cy = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
    return img[cy][cx];
  endfunction

  function automatic logic [15:0] model(input int x, input int y);
    int gx, gy, ax, ay, dir;
    gx = (px(x+1, y-1) + 2*px(x+1, y) + px(x+1, y+1))
       - (px(x-1, y-1) + 2*px(x-1, y) + px(x-1, y+1));
    gy = (px(x-1, y+1) + 2*px(x, y+1) + px(x+1, y+1))
       - (px(x-1, y-1) + 2*px(x, y-1) + px(x+1, y-1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if ((gx == 0 && gy == 0) || ay * 256 < ax * 106) dir = 0;
    else if (ay * 256 > ax * 618)                    dir = 2;
    else if ((gx >= 0) == (gy >= 0))                 dir = 1;
    else                                             dir = 3;
    return {3'b000, 2'(dir), 11'(ax + ay)};
  endfunction

  task automatic set_pattern(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (pat)
          1:       img[y][x] = 100;
          2:       img[y][x] = (x >= 4) ? 200 : 0;
          3:       img[y][x] = (y >= 2) ? 50 : 0;
          4:       img[y][x] = (x == 0 && y == 0) ? 255 : 0;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
  endtask

  // Drives n_beats of the current image; expects to start at posedge+1.
  task automatic send_frame(input int n_beats, input int user_pos);
    bit acc;
    int waited;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back('{model(x, y), (x == W - 1), (x == 0 && y == 0)});
    for (int i = 0; i < n_beats; i++) begin
      s_tdata  = 8'(img[i / W][i % W]);
      s_tvalid = 1'b1;
      s_tuser  = (i == user_pos);
      s_tlast  = ((i % W) == W - 1);
      acc      = 1'b0;
      waited   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk);
        #1;
        waited++;
        if (waited > 1000) abort("s_tready_timeout", waited);
      end
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2 * W) @(posedge clk);
    #1;
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (prev_stall) begin
        check("stall_valid_held", m_tvalid, 1);
        check("stall_data_held", {m_tuser, m_tlast, m_tdata}, prev_out);
      end
      if (m_tvalid && m_tready) begin
        check("output_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("m_tdata", m_tdata, e.data);
          check("m_tlast", m_tlast, e.last);
          check("m_tuser", m_tuser, e.user);
        end
        if (m_tuser) pos = 0;
        if (pos < N) cap[pos] = m_tdata;
        pos++;
        frame_outs++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tuser, m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    spots.push_back('{1, 0, 0, 0,    0});
    spots.push_back('{1, 7, 3, 0,    0});
    spots.push_back('{2, 3, 0, 800,  0});
    spots.push_back('{2, 4, 2, 800,  0});
    spots.push_back('{2, 3, 3, 800,  0});
    spots.push_back('{2, 2, 2, 0,    0});
    spots.push_back('{2, 5, 0, 0,    0});
    spots.push_back('{2, 0, 1, 0,    0});
    spots.push_back('{3, 0, 1, 200,  2});
    spots.push_back('{3, 5, 2, 200,  2});
    spots.push_back('{3, 3, 0, 0,    0});
    spots.push_back('{3, 7, 3, 0,    0});
    spots.push_back('{4, 0, 0, 1530, 1});
    spots.push_back('{4, 1, 1, 510,  1});
    spots.push_back('{4, 3, 3, 0,    0});

    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_s_tready", s_tready, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int p = 1; p <= 4; p++) begin
      set_pattern(p);
      frame_outs = 0;
      send_frame(N, 0);
      drain();
      check($sformatf("pat%0d_beats", p), frame_outs, N);
      foreach (spots[i])
        if (spots[i].pat == p) begin
          check($sformatf("pat%0d_mag_x%0d_y%0d", p, spots[i].x, spots[i].y),
                cap[spots[i].y * W + spots[i].x][10:0], spots[i].mag);
          check($sformatf("pat%0d_dir_x%0d_y%0d", p, spots[i].x, spots[i].y),
                cap[spots[i].y * W + spots[i].x][12:11], spots[i].dir);
        end
    end
    check("frame_err_clean", frame_err, 0);

    set_pattern(5);
    send_frame(N, 0);
    drain();
    ref_cap    = cap;
    rand_ready = 1'b1;
    frame_outs = 0;
    send_frame(N, 0);
    drain();
    rand_ready = 1'b0;
    check("stall_run_beats", frame_outs, N);
    for (int i = 0; i < N; i++)
      check($sformatf("stall_vs_free_%0d", i), cap[i], ref_cap[i]);

    set_pattern(6);
    send_frame(20, 0);
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tdata", m_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en     = 1'b1;
    frame_outs = 0;
    set_pattern(7);
    send_frame(N, 0);
    set_pattern(8);
    send_frame(N, 0);
    drain();
    check("after_rst_beats", frame_outs, 2 * N);
    check("after_rst_frame_err", frame_err, 0);

    set_pattern(9);
    frame_outs = 0;
    send_frame(N, 5);
    drain();
    check("bad_tuser_beats", frame_outs, N);
    check("bad_tuser_frame_err", frame_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
